// File: rtl/stim_gen_pkg.sv
// Shared types and constants for the exhaustive stimulus generator.
// Sweep modes, FSM states and the MISR feedback polynomial.
package stim_gen_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'b00,
        MODE_GRAY = 2'b01,
        MODE_WALK = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam logic [15:0] POLY = 16'h1021;

endpackage

// File: rtl/exhaustive_stim_gen_if.sv
// Bundle between the stimulus generator and whoever drives it.
// The slave side is the generator; the master side owns start/mode/resp.
interface exhaustive_stim_gen_if #(
    parameter int WIDTH = 6,
    parameter int SIG_W = 16
);
    logic             start;
    logic [1:0]       mode;
    logic             resp;
    logic [WIDTH-1:0] pattern;
    logic             pattern_valid;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   ones_cnt;
    logic [SIG_W-1:0] signature;

    modport master (
        output start, mode, resp,
        input  pattern, pattern_valid, busy, done, ones_cnt, signature
    );

    modport slave (
        input  start, mode, resp,
        output pattern, pattern_valid, busy, done, ones_cnt, signature
    );
endinterface

// File: rtl/misr.sv
// Single-input MISR compacting the DUT response stream.
// clr has priority over en so a new sweep always starts from zero.
module misr
    import stim_gen_pkg::*;
#(
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);
    localparam logic [SIG_W-1:0] POLY_W = SIG_W'(POLY);

    logic [SIG_W-1:0] sig_q, sig_d;

    // Next signature: shift, fold in polynomial on MSB, xor response.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY_W : '0)
                  ^ {{(SIG_W-1){1'b0}}, din};
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;
endmodule

// File: rtl/exhaustive_stim_gen.sv
// Sweeps every stimulus vector in binary, Gray or walking-one order,
// counting ones and compacting the response into a MISR signature.
module exhaustive_stim_gen
    import stim_gen_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int SIG_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    exhaustive_stim_gen_if.slave bus
);
    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH:0]   idx_q, idx_d;
    logic [WIDTH:0]   ones_q, ones_d;
    logic [WIDTH:0]   last_idx;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             clr;
    logic             en;

    function automatic logic [WIDTH-1:0] pat_of(mode_e m, logic [WIDTH:0] k);
        logic [WIDTH-1:0] b;
        b = k[WIDTH-1:0];
        case (m)
            MODE_GRAY: pat_of = b ^ (b >> 1);
            MODE_WALK: pat_of = {{(WIDTH-1){1'b0}}, 1'b1} << k;
            default:   pat_of = b;
        endcase
    endfunction

    assign last_idx = (mode_q == MODE_WALK)
                    ? (WIDTH+1)'(WIDTH-1)
                    : {1'b0, {WIDTH{1'b1}}};

    // Next state, sweep index, ones counter and registered pattern.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        clr     = 1'b0;
        en      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d  = mode_e'(bus.mode);
                    idx_d   = '0;
                    ones_d  = '0;
                    clr     = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                en     = 1'b1;
                ones_d = ones_q + (WIDTH+1)'(bus.resp);
                if (idx_q == last_idx) state_d = S_DONE;
                else                   idx_d   = idx_q + 1'b1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        pat_d = (state_d == S_RUN) ? pat_of(mode_d, idx_d) : '0;
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_BIN;
            idx_q   <= '0;
            ones_q  <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            pat_q   <= pat_d;
        end
    end

    misr #(.SIG_W(SIG_W)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .din   (bus.resp),
        .sig   (bus.signature)
    );

    assign bus.pattern       = pat_q;
    assign bus.pattern_valid = (state_q == S_RUN);
    assign bus.busy          = (state_q == S_RUN);
    assign bus.done          = (state_q == S_DONE);
    assign bus.ones_cnt      = ones_q;
endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Self-checking bench for exhaustive_stim_gen with a combinational
// response model and a sequence-level reference of each sweep.
module tb_exhaustive_stim_gen;
    localparam int W  = 6;
    localparam int SW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    exhaustive_stim_gen_if #(.WIDTH(W), .SIG_W(SW)) bus();

    exhaustive_stim_gen #(.WIDTH(W), .SIG_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    int         resp_sel;
    logic [W-1:0] resp_mask;

    function automatic logic m_resp(int sel, logic [W-1:0] p, logic [W-1:0] mask);
        case (sel)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return p[0];
            default: return ^(p & mask);
        endcase
    endfunction

    // Combinational DUT stand-in driven off the current pattern.
    always_comb bus.resp = m_resp(resp_sel, bus.pattern, resp_mask);

    logic [W-1:0] cap[$];
    int           cap_done_cyc;
    int           cap_ndone;
    int           cap_proto;

    logic [W-1:0] exp_q[$];
    int           exp_ones;
    int           exp_sig;
    int           exp_done;

    task automatic model(input int m, input int sel, input logic [W-1:0] mask);
        int len;
        int v;
        logic [W-1:0] p;
        len = (m == 2) ? W : (1 << W);
        exp_q.delete();
        exp_ones = 0;
        exp_sig  = 0;
        for (int k = 0; k < len; k++) begin
            case (m)
                1:       v = k ^ (k >> 1);
                2:       v = 1 << k;
                default: v = k;
            endcase
            p = W'(v);
            exp_q.push_back(p);
            exp_ones += int'(m_resp(sel, p, mask));
            v = (exp_sig * 2) % 65536;
            if (exp_sig >= 32768) v = v ^ 'h1021;
            exp_sig = v ^ int'(m_resp(sel, p, mask));
        end
        exp_done = len + 1;
    endtask

    task automatic run_sweep(input int m, input int perturb_at);
        int cyc;
        bit fin;
        cap.delete();
        cap_done_cyc = -1;
        cap_ndone    = 0;
        cap_proto    = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m[1:0];
        cyc = 0;
        fin = 0;
        while (!fin && cyc < (1 << W) + 16) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) bus.start = 1'b0;
            if (perturb_at > 0 && cyc == perturb_at) begin
                bus.start = 1'b1;
                bus.mode  = ~m[1:0];
            end
            if (perturb_at > 0 && cyc == perturb_at + 1) bus.start = 1'b0;
            if (bus.pattern_valid) cap.push_back(bus.pattern);
            else if (bus.pattern !== '0) cap_proto++;
            if (bus.busy !== bus.pattern_valid) cap_proto++;
            if (bus.done) begin
                cap_ndone++;
                if (cap_done_cyc < 0) cap_done_cyc = cyc;
                if (bus.busy || bus.pattern_valid) cap_proto++;
            end
            if (cap_done_cyc > 0 && cyc >= cap_done_cyc + 2) fin = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.pattern, bus.pattern_valid, bus.busy, bus.done} !== '0) begin
            n_err++;
            $display("FAIL reset_ctl got %h want 0",
                     {bus.pattern, bus.pattern_valid, bus.busy, bus.done});
        end
        n_vec++;
        if (bus.ones_cnt !== '0 || bus.signature !== '0) begin
            n_err++;
            $display("FAIL reset_cnt got ones=%0d sig=%h want 0/0",
                     bus.ones_cnt, bus.signature);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.pattern_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset got valid=%b done=%b want 0/0",
                     bus.pattern_valid, bus.done);
        end
    endtask

    task automatic test_binary_zero();
        resp_sel = 0;
        model(0, 0, '0);
        run_sweep(0, 0);
        n_vec++;
        if (cap.size() !== 64) begin
            n_err++;
            $display("FAIL bin0_len got %0d want 64", cap.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_vec++;
            if (cap[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL bin0_pat[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
        n_vec++;
        if (cap_done_cyc !== 65 || cap_ndone !== 1 || cap_proto !== 0) begin
            n_err++;
            $display("FAIL bin0_done got cyc=%0d n=%0d proto=%0d want 65/1/0",
                     cap_done_cyc, cap_ndone, cap_proto);
        end
        n_vec++;
        if (bus.ones_cnt !== '0 || bus.signature !== '0) begin
            n_err++;
            $display("FAIL bin0_result got ones=%0d sig=%h want 0/0000",
                     bus.ones_cnt, bus.signature);
        end
    endtask

    task automatic test_binary_lsb();
        resp_sel = 2;
        model(0, 2, '0);
        run_sweep(0, 0);
        n_vec++;
        if (int'(bus.ones_cnt) !== 32 || exp_ones !== 32) begin
            n_err++;
            $display("FAIL binlsb_ones got %0d want 32", bus.ones_cnt);
        end
        n_vec++;
        if (int'(bus.signature) !== exp_sig) begin
            n_err++;
            $display("FAIL binlsb_sig got %h want %h", bus.signature, exp_sig[15:0]);
        end
        n_vec++;
        if (cap_done_cyc !== exp_done || cap_ndone !== 1) begin
            n_err++;
            $display("FAIL binlsb_done got cyc=%0d n=%0d want %0d/1",
                     cap_done_cyc, cap_ndone, exp_done);
        end
    endtask

    task automatic test_gray();
        int bad;
        resp_sel = 3;
        resp_mask = 6'b101101;
        model(1, 3, resp_mask);
        run_sweep(1, 0);
        n_vec++;
        if (cap.size() !== 64) begin
            n_err++;
            $display("FAIL gray_len got %0d want 64", cap.size());
        end
        bad = 0;
        for (int i = 1; i < cap.size(); i++)
            if ($countones(cap[i] ^ cap[i-1]) != 1) bad++;
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL gray_onebit got %0d bad steps want 0", bad);
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_vec++;
            if (cap[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL gray_pat[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
        n_vec++;
        if (cap.size() == 0 || cap[cap.size()-1] !== 6'b100000) begin
            n_err++;
            $display("FAIL gray_last got %b want 100000",
                     (cap.size() == 0) ? 6'b0 : cap[cap.size()-1]);
        end
        n_vec++;
        if (int'(bus.ones_cnt) !== exp_ones || int'(bus.signature) !== exp_sig) begin
            n_err++;
            $display("FAIL gray_result got ones=%0d sig=%h want %0d/%h",
                     bus.ones_cnt, bus.signature, exp_ones, exp_sig[15:0]);
        end
    endtask

    task automatic test_walk();
        resp_sel = 1;
        model(2, 1, '0);
        run_sweep(2, 0);
        n_vec++;
        if (cap.size() !== W) begin
            n_err++;
            $display("FAIL walk_len got %0d want %0d", cap.size(), W);
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_vec++;
            if (cap[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL walk_pat[%0d] got %b want %b", i, cap[i], exp_q[i]);
            end
        end
        n_vec++;
        if (int'(bus.ones_cnt) !== 6 || cap_done_cyc !== 7 || cap_ndone !== 1) begin
            n_err++;
            $display("FAIL walk_done got ones=%0d cyc=%0d n=%0d want 6/7/1",
                     bus.ones_cnt, cap_done_cyc, cap_ndone);
        end
        n_vec++;
        if (int'(bus.signature) !== exp_sig) begin
            n_err++;
            $display("FAIL walk_sig got %h want %h", bus.signature, exp_sig[15:0]);
        end
    endtask

    task automatic test_start_ignored();
        resp_sel = 3;
        resp_mask = 6'b010011;
        model(0, 3, resp_mask);
        run_sweep(0, 10);
        n_vec++;
        if (cap.size() !== 64) begin
            n_err++;
            $display("FAIL perturb_len got %0d want 64", cap.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_vec++;
            if (cap[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL perturb_pat[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
        n_vec++;
        if (cap_ndone !== 1 || cap_done_cyc !== 65 || cap_proto !== 0) begin
            n_err++;
            $display("FAIL perturb_done got n=%0d cyc=%0d proto=%0d want 1/65/0",
                     cap_ndone, cap_done_cyc, cap_proto);
        end
        n_vec++;
        if (int'(bus.ones_cnt) !== exp_ones || int'(bus.signature) !== exp_sig) begin
            n_err++;
            $display("FAIL perturb_result got ones=%0d sig=%h want %0d/%h",
                     bus.ones_cnt, bus.signature, exp_ones, exp_sig[15:0]);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        resp_sel = 1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 2'b00;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++;
        if (bus.pattern !== W'(20) || int'(bus.ones_cnt) !== 20) begin
            n_err++;
            $display("FAIL mid_pre got pat=%0d ones=%0d want 20/20",
                     bus.pattern, bus.ones_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.pattern, bus.pattern_valid, bus.busy, bus.done,
             bus.ones_cnt, bus.signature} !== '0) begin
            n_err++;
            $display("FAIL mid_reset got pat=%h v=%b b=%b d=%b ones=%0d sig=%h want all 0",
                     bus.pattern, bus.pattern_valid, bus.busy, bus.done,
                     bus.ones_cnt, bus.signature);
        end
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.pattern_valid) dones++;
        end
        n_vec++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL mid_nodone got %0d activity cycles want 0", dones);
        end
        resp_sel = 2;
        model(0, 2, '0);
        run_sweep(0, 0);
        n_vec++;
        if (cap.size() !== 64 || cap_done_cyc !== 65 || cap_ndone !== 1) begin
            n_err++;
            $display("FAIL mid_resweep got len=%0d cyc=%0d n=%0d want 64/65/1",
                     cap.size(), cap_done_cyc, cap_ndone);
        end
        n_vec++;
        if (int'(bus.ones_cnt) !== 32 || int'(bus.signature) !== exp_sig) begin
            n_err++;
            $display("FAIL mid_result got ones=%0d sig=%h want 32/%h",
                     bus.ones_cnt, bus.signature, exp_sig[15:0]);
        end
    endtask

    task automatic test_random();
        int m;
        int badp;
        for (int it = 0; it < 6; it++) begin
            m         = $urandom_range(0, 3);
            resp_sel  = $urandom_range(0, 3);
            resp_mask = W'($urandom);
            model(m, resp_sel, resp_mask);
            run_sweep(m, 0);
            badp = 0;
            for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
                if (cap[i] !== exp_q[i]) badp++;
            n_vec++;
            if (cap.size() !== exp_q.size() || badp !== 0) begin
                n_err++;
                $display("FAIL rnd%0d_pat mode=%0d got len=%0d bad=%0d want %0d/0",
                         it, m, cap.size(), badp, exp_q.size());
            end
            n_vec++;
            if (int'(bus.ones_cnt) !== exp_ones || int'(bus.signature) !== exp_sig
                || cap_done_cyc !== exp_done || cap_ndone !== 1) begin
                n_err++;
                $display("FAIL rnd%0d_res got ones=%0d sig=%h cyc=%0d want %0d/%h/%0d",
                         it, bus.ones_cnt, bus.signature, cap_done_cyc,
                         exp_ones, exp_sig[15:0], exp_done);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        resp_sel  = 0;
        resp_mask = '0;
        test_reset();
        test_binary_zero();
        test_binary_lsb();
        test_gray();
        test_walk();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
